// File: rtl/debounce_pkg.sv
// Shared types and defaults for the signal debouncer: FSM state encoding,
// default parameter values and small state-classification helpers.
package debounce_pkg;

  localparam int unsigned DEF_SYNC_STAGES     = 32'd2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd16;

  typedef enum logic [1:0] {
    ST_LOW   = 2'b00,
    ARM_HIGH = 2'b01,
    ST_HIGH  = 2'b10,
    ARM_LOW  = 2'b11
  } deb_state_t;

  function automatic logic is_arm(input deb_state_t s);
    return (s == ARM_HIGH) || (s == ARM_LOW);
  endfunction

  // Stable state that corresponds to a given committed output level.
  function automatic deb_state_t stable_of(input logic level);
    return level ? ST_HIGH : ST_LOW;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain;
// q is the last stage of a DEPTH-deep chain cleared by asynchronous reset.
module bit_sync #(
  parameter int unsigned DEPTH = 32'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_chain;

  // shift chain, oldest sample at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {DEPTH{1'b0}};
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], d};
    end
  end

  assign q = r_chain[DEPTH-1];

endmodule

// File: rtl/signal_debouncer.sv
// Debounces an asynchronous level: synchronizes it, then only accepts a new
// level after it holds for DEBOUNCE_CYCLES consecutive enabled clocks.
module signal_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  input  logic en,
  output logic sig_out,
  output logic busy,
  output logic bounce
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sig_out;
  logic             w_sig_out_nxt;
  logic             r_busy;
  logic             r_bounce;
  logic             w_bounce_nxt;

  bit_sync #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (w_sync)
  );

  // Next-state logic. An abort by the synchronized level takes priority over
  // a commit, so a toggle on the last qualifying clock yields a bounce.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sig_out_nxt = r_sig_out;
    w_bounce_nxt  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (en && w_sync) begin
          w_state_nxt = ARM_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      ARM_HIGH: begin
        if (!en) begin
          w_state_nxt = stable_of(r_sig_out);
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (!w_sync) begin
          w_state_nxt  = ST_LOW;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_bounce_nxt = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_HIGH;
          w_cnt_nxt     = {CNT_W{1'b0}};
          w_sig_out_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (en && !w_sync) begin
          w_state_nxt = ARM_LOW;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      ARM_LOW: begin
        if (!en) begin
          w_state_nxt = stable_of(r_sig_out);
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (w_sync) begin
          w_state_nxt  = ST_HIGH;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_bounce_nxt = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_LOW;
          w_cnt_nxt     = {CNT_W{1'b0}};
          w_sig_out_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt   = ST_LOW;
        w_cnt_nxt     = {CNT_W{1'b0}};
        w_sig_out_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and all outputs update together; busy tracks the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOW;
      r_cnt     <= {CNT_W{1'b0}};
      r_sig_out <= 1'b0;
      r_busy    <= 1'b0;
      r_bounce  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sig_out <= w_sig_out_nxt;
      r_busy    <= is_arm(w_state_nxt);
      r_bounce  <= w_bounce_nxt;
    end
  end

  assign sig_out = r_sig_out;
  assign busy    = r_busy;
  assign bounce  = r_bounce;

endmodule

// File: tb/tb_signal_debouncer.sv
// Self-checking bench for signal_debouncer: directed latency/boundary scenarios
// plus random bouncing input, compared every clock against a run-length model.
module tb_signal_debouncer;

  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_in;
  logic en;
  logic sig_out;
  logic busy;
  logic bounce;

  int n_checks = 0;
  int n_fails  = 0;
  int edge_no  = 0;

  // model: delay line for the synchronizer, run length of the disagreeing level
  logic hist [S];
  int   run;
  logic m_out;
  logic m_busy;
  logic m_bounce;

  signal_debouncer #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .en      (en),
    .sig_out (sig_out),
    .busy    (busy),
    .bounce  (bounce)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", tag, got, exp, $time, edge_no);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) hist[i] = 1'b0;
    run      = 0;
    m_out    = 1'b0;
    m_busy   = 1'b0;
    m_bounce = 1'b0;
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare outputs.
  task automatic tick();
    logic s_v;
    logic e_v;
    logic sy;
    s_v = sig_in;
    e_v = en;
    @(posedge clk);
    sy = hist[S-1];
    for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s_v;
    m_bounce = 1'b0;
    if (!e_v) begin
      run = 0;
    end else if (sy != m_out) begin
      run++;
      if (run == D) begin
        m_out = ~m_out;
        run   = 0;
      end
    end else begin
      if (run > 0) m_bounce = 1'b1;
      run = 0;
    end
    m_busy = (run > 0);
    edge_no++;
    #1;
    check_eq("sig_out", sig_out, m_out);
    check_eq("busy", busy, m_busy);
    check_eq("bounce", bounce, m_bounce);
  endtask

  initial begin
    int nb;
    int seen_hi;
    rst_n  = 1'b1;
    sig_in = 1'b0;
    en     = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_sig_out", sig_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bounce", bounce, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    model_reset();
    edge_no = 0;

    // clean rising step applied before edge 10
    repeat (9) tick();
    sig_in = 1'b1;
    repeat (2) tick();
    check_eq("step_busy_e11", busy, 0);
    tick();
    check_eq("step_busy_e12", busy, 1);
    repeat (2) tick();
    check_eq("step_out_e14", sig_out, 0);
    tick();
    check_eq("step_out_e15", sig_out, 1);
    check_eq("step_busy_e15", busy, 0);

    // falling qualification
    repeat (3) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    check_eq("fall_out_k4", sig_out, 1);
    tick();
    check_eq("fall_out_k5", sig_out, 0);

    // short bounce: 2 clocks high
    repeat (8) tick();
    sig_in = 1'b1;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) sig_in = 1'b0;
      tick();
      nb += int'(bounce);
      if (sig_out) check_eq("bnc_out_low", sig_out, 0);
    end
    check_eq("bnc_count", nb, 1);
    check_eq("bnc_busy_end", busy, 0);

    // boundary: 3 clocks high aborts
    sig_in = 1'b1;
    nb = 0;
    seen_hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) sig_in = 1'b0;
      tick();
      nb += int'(bounce);
      if (sig_out) seen_hi = 1;
    end
    check_eq("b3_count", nb, 1);
    check_eq("b3_commit", seen_hi, 0);

    // boundary: 4 clocks high commits
    sig_in = 1'b1;
    nb = 0;
    seen_hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) sig_in = 1'b0;
      tick();
      nb += int'(bounce);
      if (sig_out) seen_hi = 1;
    end
    check_eq("b4_count", nb, 0);
    check_eq("b4_commit", seen_hi, 1);
    check_eq("b4_out_end", sig_out, 0);

    // en dropped mid ARM_HIGH with cnt=2
    sig_in = 1'b1;
    repeat (4) tick();
    check_eq("en_busy_arm", busy, 1);
    en = 1'b0;
    tick();
    check_eq("en_busy_off", busy, 0);
    check_eq("en_bounce_off", bounce, 0);
    check_eq("en_out_off", sig_out, 0);
    en = 1'b1;
    repeat (3) tick();
    check_eq("en_out_re3", sig_out, 0);
    tick();
    check_eq("en_out_re4", sig_out, 1);

    // reset pulsed mid ARM_HIGH
    sig_in = 1'b0;
    repeat (10) tick();
    sig_in = 1'b1;
    repeat (4) tick();
    check_eq("rr_busy_arm", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rr_out_async", sig_out, 0);
    check_eq("rr_busy_async", busy, 0);
    check_eq("rr_bounce_async", bounce, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("rr_out_k4", sig_out, 0);
    tick();
    check_eq("rr_out_k5", sig_out, 1);

    // random runs of bouncing input with occasional enable drops
    for (int i = 0; i < 300; i++) begin
      sig_in = 1'($urandom_range(1, 0));
      en     = ($urandom_range(15, 0) != 0);
      repeat ($urandom_range(7, 1)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
